// File: rtl/cache_parameters.sv
// rtl/cache_parameters.sv - shared cache/memory types plus arbiter state and owner encodings
package cache_parameters;

  localparam int BLOCK_SIZE = 4;
  localparam int WORD_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  typedef struct packed {
    logic                                 cs;
    logic                                 rw;
    logic [ADDR_WIDTH-1:0]                addr;
    logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] data;
  } memory_request_t;

  typedef struct packed {
    logic                                 ack;
    logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] data;
  } memory_response_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_t;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_I    = 2'b01;
  localparam logic [1:0] OWNER_D    = 2'b10;

endpackage

// File: rtl/mem_arbiter_timeout_counter.sv
// rtl/mem_arbiter_timeout_counter.sv - watchdog for a granted memory transaction that never acks
module arb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic ack,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clear, enable, ack};
      assign expired = 1'b0;
    end else begin : g_on
      localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
      logic [CNT_WIDTH-1:0] cnt;

      // cnt holds the number of ack-less granted cycles before the current one
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
        end else if (clear) begin
          cnt <= '0;
        end else if (enable && !ack) begin
          cnt <= cnt + CNT_WIDTH'(1);
        end
      end

      assign expired = enable && !ack && (cnt == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache arbiter for the shared memory port; MEM_ARB_ROUND_ROBIN_EN selects round-robin ties
module mem_arbiter
  import cache_parameters::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  memory_request_t  i_req,
  output memory_response_t i_res,
  input  memory_request_t  d_req,
  output memory_response_t d_res,
  output memory_request_t  mem_req,
  input  memory_response_t mem_res,
  output logic [1:0]       owner,
  output logic             timeout_err
);

  arb_state_t state, next_state;
  logic       granted;
  logic       owner_cs;
  logic       owner_ack;
  logic       grant_entry;
  logic       expired;
  logic       d_wins_tie;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_i <= 1'b1;
    end else if (grant_entry) begin
      last_i <= (next_state == ARB_GNT_I);
    end
  end

  assign d_wins_tie = last_i;
`else
  assign d_wins_tie = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (expired) begin
      timeout_err <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    granted    = (state != ARB_IDLE);
    owner_cs   = 1'b0;
    if (state == ARB_GNT_I) owner_cs = i_req.cs;
    if (state == ARB_GNT_D) owner_cs = d_req.cs;
    owner_ack  = owner_cs && mem_res.ack;

    case (state)
      ARB_IDLE: begin
        if (i_req.cs && d_req.cs) begin
          next_state = d_wins_tie ? ARB_GNT_D : ARB_GNT_I;
        end else if (i_req.cs) begin
          next_state = ARB_GNT_I;
        end else if (d_req.cs) begin
          next_state = ARB_GNT_D;
        end
      end
      ARB_GNT_I: begin
        if (!i_req.cs || expired) begin
          next_state = ARB_IDLE;
        end else if (mem_res.ack) begin
          next_state = d_req.cs ? ARB_GNT_D : ARB_IDLE;
        end
      end
      ARB_GNT_D: begin
        if (!d_req.cs || expired) begin
          next_state = ARB_IDLE;
        end else if (mem_res.ack) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          next_state = i_req.cs ? ARB_GNT_I : ARB_IDLE;
`else
          next_state = d_req.cs ? ARB_GNT_D : (i_req.cs ? ARB_GNT_I : ARB_IDLE);
`endif
        end
      end
      default: next_state = ARB_IDLE;
    endcase

    // A back-to-back regrant of D counts as a fresh grant for the watchdog
    grant_entry = (next_state != ARB_IDLE) && ((state == ARB_IDLE) || owner_ack);
  end

  always_comb begin
    mem_req    = '0;
    owner      = OWNER_NONE;
    i_res      = '0;
    d_res      = '0;
    case (state)
      ARB_GNT_I: begin
        mem_req = i_req;
        owner   = OWNER_I;
      end
      ARB_GNT_D: begin
        mem_req = d_req;
        owner   = OWNER_D;
      end
      default: ;
    endcase
    if (granted) begin
      i_res.data = mem_res.data;
      d_res.data = mem_res.data;
    end
    i_res.ack = (state == ARB_GNT_I) && owner_ack;
    d_res.ack = (state == ARB_GNT_D) && owner_ack;
  end

  arb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (grant_entry),
    .enable (granted && owner_cs),
    .ack    (mem_res.ack),
    .expired(expired)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import cache_parameters::*;

  logic             clk = 1'b0;
  logic             rst;
  memory_request_t  i_req, d_req, mem_req;
  memory_response_t i_res, d_res, mem_res;
  logic [1:0]       owner;
  logic             timeout_err;
  logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] exp_data;
  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_res      (i_res),
    .d_req      (d_req),
    .d_res      (d_res),
    .mem_req    (mem_req),
    .mem_res    (mem_res),
    .owner      (owner),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    i_req = '0;
    d_req = '0;
    mem_res.ack = 1'b0;
    mem_res.data = exp_data;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    i_req = '0;
    d_req = '0;
    d_req.cs = 1'b1;
    mem_res.ack = 1'b1;
    mem_res.data = exp_data;
    tick();
    n_cmp++; if (owner !== OWNER_NONE) begin n_err++; $display("FAIL reset_owner: got %0h want 0", owner); end
    n_cmp++; if (mem_req !== '0) begin n_err++; $display("FAIL reset_mem_req: got %h want 0", mem_req); end
    n_cmp++; if (i_res !== '0 || d_res !== '0) begin n_err++; $display("FAIL reset_res: got i=%h d=%h want 0", i_res, d_res); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    d_req = '0;
    mem_res.ack = 1'b0;
  endtask

  task automatic test_lone_read;
    do_reset();
    i_req.cs = 1'b1; i_req.rw = 1'b0; i_req.addr = 32'h100;
    #1;
    n_cmp++; if (mem_req.cs !== 1'b0) begin n_err++; $display("FAIL lone_latency: got cs=%b want 0", mem_req.cs); end
    tick();
    n_cmp++; if (owner !== OWNER_I) begin n_err++; $display("FAIL lone_owner: got %0h want 1", owner); end
    n_cmp++; if (mem_req.cs !== 1'b1 || mem_req.addr !== 32'h100) begin n_err++; $display("FAIL lone_addr: got cs=%b addr=%h want 1/100", mem_req.cs, mem_req.addr); end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++; if (i_res.ack !== 1'b0 || d_res.ack !== 1'b0) begin n_err++; $display("FAIL lone_early_ack: got i=%b d=%b want 0/0", i_res.ack, d_res.ack); end
    end
    tick();
    mem_res.ack = 1'b1;
    #1;
    n_cmp++; if (i_res.ack !== 1'b1 || d_res.ack !== 1'b0) begin n_err++; $display("FAIL lone_ack: got i=%b d=%b want 1/0", i_res.ack, d_res.ack); end
    n_cmp++; if (i_res.data !== exp_data || d_res.data !== exp_data) begin n_err++; $display("FAIL lone_data: got i=%h d=%h want %h", i_res.data, d_res.data, exp_data); end
    tick();
    mem_res.ack = 1'b0;
    i_req = '0;
    #1;
    n_cmp++; if (owner !== OWNER_NONE || mem_req !== '0) begin n_err++; $display("FAIL lone_release: got owner=%0h req=%h want 0", owner, mem_req); end
  endtask

  task automatic test_tie;
    do_reset();
    i_req.cs = 1'b1; i_req.addr = 32'h200;
    d_req.cs = 1'b1; d_req.addr = 32'h300;
    tick();
    n_cmp++; if (owner !== OWNER_D || mem_req.addr !== 32'h300) begin n_err++; $display("FAIL tie_first: got owner=%0h addr=%h want 2/300", owner, mem_req.addr); end
    tick();
    mem_res.ack = 1'b1;
    #1;
    n_cmp++; if (d_res.ack !== 1'b1 || i_res.ack !== 1'b0) begin n_err++; $display("FAIL tie_d_ack: got d=%b i=%b want 1/0", d_res.ack, i_res.ack); end
    tick();
    mem_res.ack = 1'b0;
    d_req.cs = 1'b0;
    #1;
`ifndef MEM_ARB_ROUND_ROBIN_EN
    n_cmp++; if (owner !== OWNER_D || mem_req.cs !== 1'b0) begin n_err++; $display("FAIL tie_regrant: got owner=%0h cs=%b want 2/0", owner, mem_req.cs); end
    tick();
    n_cmp++; if (owner !== OWNER_NONE) begin n_err++; $display("FAIL tie_abort: got owner=%0h want 0", owner); end
    tick();
`endif
    n_cmp++; if (owner !== OWNER_I || mem_req.addr !== 32'h200) begin n_err++; $display("FAIL tie_second: got owner=%0h addr=%h want 1/200", owner, mem_req.addr); end
    mem_res.ack = 1'b1;
    #1;
    n_cmp++; if (i_res.ack !== 1'b1 || d_res.ack !== 1'b0) begin n_err++; $display("FAIL tie_i_ack: got i=%b d=%b want 1/0", i_res.ack, d_res.ack); end
    tick();
    mem_res.ack = 1'b0;
    i_req = '0;
    #1;
    n_cmp++; if (owner !== OWNER_NONE) begin n_err++; $display("FAIL tie_release: got owner=%0h want 0", owner); end
  endtask

`ifndef MEM_ARB_ROUND_ROBIN_EN
  task automatic test_fixed_priority;
    do_reset();
    i_req.cs = 1'b1; i_req.addr = 32'h600;
    d_req.cs = 1'b1; d_req.rw = 1'b1; d_req.addr = 32'h500;
    tick();
    n_cmp++; if (owner !== OWNER_D || mem_req.addr !== 32'h500) begin n_err++; $display("FAIL fixed_first: got owner=%0h addr=%h want 2/500", owner, mem_req.addr); end
    mem_res.ack = 1'b1;
    tick();
    mem_res.ack = 1'b0;
    d_req.rw = 1'b0; d_req.addr = 32'h540;
    #1;
    n_cmp++; if (owner !== OWNER_D || mem_req.cs !== 1'b1 || mem_req.addr !== 32'h540) begin n_err++; $display("FAIL fixed_second: got owner=%0h cs=%b addr=%h want 2/1/540", owner, mem_req.cs, mem_req.addr); end
    mem_res.ack = 1'b1;
    #1;
    n_cmp++; if (d_res.ack !== 1'b1 || i_res.ack !== 1'b0) begin n_err++; $display("FAIL fixed_second_ack: got d=%b i=%b want 1/0", d_res.ack, i_res.ack); end
    tick();
    mem_res.ack = 1'b0;
    d_req = '0;
    tick();
    n_cmp++; if (owner !== OWNER_NONE) begin n_err++; $display("FAIL fixed_idle: got owner=%0h want 0", owner); end
    tick();
    n_cmp++; if (owner !== OWNER_I || mem_req.addr !== 32'h600) begin n_err++; $display("FAIL fixed_i_grant: got owner=%0h addr=%h want 1/600", owner, mem_req.addr); end
    mem_res.ack = 1'b1;
    tick();
    mem_res.ack = 1'b0;
    i_req = '0;
  endtask
`else
  task automatic test_wb_alloc;
    do_reset();
    d_req.cs = 1'b1; d_req.rw = 1'b1; d_req.addr = 32'h400;
    tick();
    n_cmp++; if (owner !== OWNER_D || mem_req.rw !== 1'b1 || mem_req.addr !== 32'h400) begin n_err++; $display("FAIL wb_first: got owner=%0h rw=%b addr=%h want 2/1/400", owner, mem_req.rw, mem_req.addr); end
    mem_res.ack = 1'b1;
    tick();
    mem_res.ack = 1'b0;
    d_req.rw = 1'b0; d_req.addr = 32'h480;
    i_req.cs = 1'b1; i_req.addr = 32'h700;
    #1;
    n_cmp++; if (owner !== OWNER_NONE) begin n_err++; $display("FAIL wb_gap: got owner=%0h want 0", owner); end
    tick();
    n_cmp++; if (owner !== OWNER_I || mem_req.addr !== 32'h700) begin n_err++; $display("FAIL wb_i_grant: got owner=%0h addr=%h want 1/700", owner, mem_req.addr); end
    mem_res.ack = 1'b1;
    tick();
    mem_res.ack = 1'b0;
    i_req = '0;
    #1;
    n_cmp++; if (owner !== OWNER_D || mem_req.rw !== 1'b0 || mem_req.addr !== 32'h480) begin n_err++; $display("FAIL wb_alloc: got owner=%0h rw=%b addr=%h want 2/0/480", owner, mem_req.rw, mem_req.addr); end
    mem_res.ack = 1'b1;
    tick();
    mem_res.ack = 1'b0;
    d_req = '0;
    #1;
    n_cmp++; if (owner !== OWNER_NONE) begin n_err++; $display("FAIL wb_release: got owner=%0h want 0", owner); end
  endtask
`endif

  task automatic test_timeout;
    do_reset();
    i_req.cs = 1'b1; i_req.addr = 32'h800;
    tick();
    d_req.cs = 1'b1; d_req.addr = 32'h900;
    for (int g = 2; g <= 8; g++) tick();
    n_cmp++; if (timeout_err !== 1'b0 || owner !== OWNER_I || mem_req.cs !== 1'b1) begin n_err++; $display("FAIL to_before: got err=%b owner=%0h cs=%b want 0/1/1", timeout_err, owner, mem_req.cs); end
    tick();
    n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_flag: got %b want 1", timeout_err); end
    n_cmp++; if (owner !== OWNER_NONE || mem_req.cs !== 1'b0 || i_res.ack !== 1'b0) begin n_err++; $display("FAIL to_release: got owner=%0h cs=%b ack=%b want 0/0/0", owner, mem_req.cs, i_res.ack); end
    tick();
    n_cmp++; if (owner !== OWNER_D || mem_req.addr !== 32'h900) begin n_err++; $display("FAIL to_d_grant: got owner=%0h addr=%h want 2/900", owner, mem_req.addr); end
    mem_res.ack = 1'b1;
    tick();
    mem_res.ack = 1'b0;
    i_req = '0;
    d_req = '0;
    #1;
    n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
  endtask

  task automatic test_reset_mid;
    d_req.cs = 1'b1; d_req.addr = 32'hA00;
    tick();
    n_cmp++; if (owner !== OWNER_D) begin n_err++; $display("FAIL rmid_grant: got owner=%0h want 2", owner); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (mem_req.cs !== 1'b0 || owner !== OWNER_NONE || timeout_err !== 1'b0) begin n_err++; $display("FAIL rmid_async: got cs=%b owner=%0h err=%b want 0/0/0", mem_req.cs, owner, timeout_err); end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (owner !== OWNER_D || mem_req.addr !== 32'hA00) begin n_err++; $display("FAIL rmid_retry: got owner=%0h addr=%h want 2/a00", owner, mem_req.addr); end
    mem_res.ack = 1'b1;
    #1;
    n_cmp++; if (d_res.ack !== 1'b1) begin n_err++; $display("FAIL rmid_ack: got %b want 1", d_res.ack); end
    tick();
    mem_res.ack = 1'b0;
    d_req = '0;
  endtask

  initial begin
    exp_data = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
    test_reset();
    test_lone_read();
    test_tie();
`ifndef MEM_ARB_ROUND_ROBIN_EN
    test_fixed_priority();
`else
    test_wb_alloc();
`endif
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single main-memory block port between the instruction cache and the data cache. It sits between the two cache instances' `mem_req`/`mem_res` ports and the memory controller. Exactly one cache owns memory at a time, and ownership is held until that transaction's ack. The block also watches for memory that never acks, through a timeout counter.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: number of cycles a granted transaction may wait for `ack`. A value of 0 disables the watchdog.
- `CNT_WIDTH`, default 11: width of the timeout counter. Must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_req`  in  `memory_request_t`  instruction-cache request (`cs`, `rw`, `addr`, `data[BLOCK_SIZE]`).
- `i_res`  out  `memory_response_t`  response to the instruction cache.
- `d_req`  in  `memory_request_t`  data-cache request.
- `d_res`  out  `memory_response_t`  response to the data cache.
- `mem_req`  out  `memory_request_t`  request to the memory controller.
- `mem_res`  in  `memory_response_t`  memory response (`ack`, `data[BLOCK_SIZE]`).
- `owner`  out  2  current grant: 00 none, 01 I, 10 D.
- `timeout_err`  out  1  sticky flag, set on watchdog expiry.

## Operation
States:
- `ARB_IDLE`: no owner.
- `ARB_GNT_I`: instruction cache owns memory.
- `ARB_GNT_D`: data cache owns memory.

Arbitration in ARB_IDLE, evaluated every cycle:
- Only I requests (`i_req.cs`=1) -> go to ARB_GNT_I.
- Only D requests (`d_req.cs`=1) -> go to ARB_GNT_D.
- Both request -> decided by the policy in Configuration.
- Neither requests -> stay in ARB_IDLE.

While granted:
- `mem_req` is a combinational copy of the owner's request.
- `mem_res.data` is broadcast to both `i_res.data` and `d_res.data`.
- `mem_res.ack` is routed only to the owner. The non-owner sees ack=0.
- In ARB_IDLE, `mem_req` is all zeros (cs=0, rw=0, addr=0, data=0), and both acks are 0.

Release from a granted state:
- Owner sees `mem_res.ack`=1 -> next cycle, if the other cache has cs=1 it is granted directly (handover with no ARB_IDLE cycle); otherwise go to ARB_IDLE.
- Owner drops cs before ack (abort) -> go to ARB_IDLE. `mem_req.cs` is already 0 in that cycle, because `mem_req` is a pass-through.
- Ack in a cycle where the owner has cs=0 is ignored and not forwarded.

Cache sequencing:
- A cache write-back followed by allocate is two separate transactions.
- The other cache may win the grant between them. This is legal, and the cache simply waits.

Watchdog:
- The counter clears when a grant is entered and increments each granted cycle without ack.
- When it reaches `TIMEOUT_CYCLES`, `timeout_err` is set, the grant is forcibly released to ARB_IDLE, and the owner receives no ack.
- `timeout_err` clears only on `rst`.

## Timing
- Reset values: state ARB_IDLE, `owner`=00, `mem_req` all zero, `i_res`/`d_res` ack=0 and data=0 (data is zero because `mem_res` is gated in idle), `timeout_err`=0, counter=0, round-robin pointer = I-last (so D wins the first tie).
- Arbitration latency: request cs rises in cycle N; grant is registered at the edge ending N; `mem_req.cs`=1 in cycle N+1.
- Ack to owner: 0-cycle combinational pass-through, in the same cycle as `mem_res.ack`.
- Handover: A's ack in cycle M, B granted in cycle M+1. There is no bubble.
- Reset asserted mid-transaction: `mem_req.cs` drops immediately (asynchronously). An in-flight memory access is abandoned, and the memory controller must tolerate this.
- Timeout: the expiry cycle is the `TIMEOUT_CYCLES`-th granted cycle without ack. `mem_req.cs`=0 from the next cycle.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - On a tie, the cache not granted most recently wins.
  - The pointer updates on every grant entry, including handover.
- `MEM_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: D always wins ties.
  - The pointer register is not synthesized.
  - Handover after an I ack still goes to D if D is pending. After a D ack with both pending, D is regranted only if `d_req.cs` is still 1; otherwise I is granted.

## Structure
- `arb_state_t` (ARB_IDLE, ARB_GNT_I, ARB_GNT_D) and the `owner` encoding constants are added to `cache_parameters`.
- `memory_request_t` and `memory_response_t` are reused from `cache_parameters`. No new struct types are needed.
- One sub-module, `arb_timeout_counter`: inputs clear/enable/ack, output `expired`, parameterised by `TIMEOUT_CYCLES`/`CNT_WIDTH`. When `TIMEOUT_CYCLES`=0 it is tied off (expired=0).
- The arbitration FSM and the muxes live in `mem_arbiter`.

## Test plan
- Lone I read:
  - Stimulus: `i_req`{cs=1, rw=0, addr=0x100}; memory acks 3 cycles after grant.
  - Required: `mem_req.addr`=0x100 from the cycle after cs; `i_res.ack`=1 in the ack cycle; `d_res.ack`=0 throughout; `owner` returns to 00.
- Simultaneous requests, round-robin enabled:
  - Stimulus: after reset, I addr=0x200 and D addr=0x300 both assert cs.
  - Required: D is granted first; on D's ack, I is granted in the next cycle; `mem_req.addr` sequence is 0x300 then 0x200.
- Fixed priority (macro undefined):
  - Stimulus: D issues two back-to-back transactions while I is pending.
  - Required: I waits until D's cs is low at the handover point, then is granted.
- Write-back then allocate from D, with I contending:
  - Stimulus: D issues rw=1 addr=0x400, then rw=0 addr=0x480; I requests after the first ack.
  - Required: grant order D, I (round-robin), D; each transaction is completed intact.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=8; I granted; memory never acks.
  - Required: after 8 granted cycles, `timeout_err`=1; `mem_req.cs`=0 in the next cycle; `owner`=00; a pending D request is then granted.
- Reset mid-transaction:
  - Stimulus: assert `rst` while D is granted.
  - Required: `mem_req.cs`=0 and `owner`=00 immediately; after reset release, a D retry is granted normally.
